// File: rtl/axi_burst_writer_pkg.sv
// Shared constants, FSM state type and helpers for the AXI burst writer.
package axi_burst_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StResp
  } state_e;

  // AWSIZE encoding for a data bus of dwid bits.
  function automatic logic [2:0] size_of(input int unsigned dwid);
    logic [2:0] s;
    case (dwid)
      8:       s = 3'd0;
      16:      s = 3'd1;
      32:      s = 3'd2;
      64:      s = 3'd3;
      128:     s = 3'd4;
      256:     s = 3'd5;
      512:     s = 3'd6;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// AXI4 write-side channels (AW, W, B) with initiator/target views.
interface axi_burst_writer_if #(
  parameter int unsigned AWID = 32,
  parameter int unsigned DWID = 32,
  parameter int unsigned LWID = 8
) ();

  logic [AWID-1:0]   awaddr;
  logic [LWID-1:0]   awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DWID-1:0]   wdata;
  logic [DWID/8-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_burst_writer_skid.sv
// Two-entry in-order buffer between the FIFO read port and the W channel.
module axi_burst_writer_skid #(
  parameter int unsigned DWID = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [DWID-1:0] push_data_i,
  input  logic            pop_i,
  output logic [DWID-1:0] head_o,
  output logic [1:0]      cnt_o
);

  logic [DWID-1:0] ent0_q, ent0_d;
  logic [DWID-1:0] ent1_q, ent1_d;
  logic [1:0]      cnt_q, cnt_d;

  // ent0 is always the head; entries shift down on pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = ent0_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/axi_burst_writer.sv
// AXI4 write initiator: one command -> AW, FIFO-fed W burst, then B; reports BRESP via done.
module axi_burst_writer
  import axi_burst_writer_pkg::*;
#(
  parameter int unsigned AWID = 32,
  parameter int unsigned DWID = 32,
  parameter int unsigned LWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [AWID-1:0]   cmd_addr_i,
  input  logic [LWID-1:0]   cmd_len_i,
  output logic              fifo_rden_o,
  input  logic [DWID-1:0]   fifo_dout_i,
  input  logic              fifo_bare_i,
  axi_burst_writer_if.master m_axi,
  output logic              done_o,
  output logic [1:0]        done_resp_o,
  output logic              busy_o
);

  localparam int unsigned CW = LWID + 1;

  state_e          state_q, state_d;
  logic [AWID-1:0] addr_q, addr_d;
  logic [LWID-1:0] len_q, len_d;
  logic [CW-1:0]   fetch_left_q, fetch_left_d;
  logic [CW-1:0]   send_left_q, send_left_d;
  logic            rd_pend_q;
  logic            done_q;
  logic [1:0]      done_resp_q, done_resp_d;

  logic            cmd_fire, aw_fire, w_fire, b_fire;
  logic [1:0]      buf_cnt;
  logic [DWID-1:0] buf_head;
  logic [2:0]      occ;

  assign cmd_ready_o = (state_q == StIdle) && !rst;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign aw_fire     = m_axi.awvalid && m_axi.awready;
  assign w_fire      = m_axi.wvalid && m_axi.wready;
  assign b_fire      = m_axi.bvalid && m_axi.bready;

  // Words already buffered or in flight from the FIFO, after this cycle's pop.
  assign occ         = 3'(buf_cnt) + 3'(rd_pend_q) - 3'(w_fire);
  assign fifo_rden_o = !rst && (state_q == StData) && !fifo_bare_i &&
                       (fetch_left_q != '0) && (occ < 3'd2);

  assign m_axi.awvalid = (state_q == StAddr);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = m_axi.awvalid ? size_of(DWID) : 3'd0;
  assign m_axi.awburst = m_axi.awvalid ? AXI_BURST_INCR : 2'b00;
  assign m_axi.wvalid  = (buf_cnt != 2'd0);
  assign m_axi.wdata   = buf_head;
  assign m_axi.wstrb   = m_axi.wvalid ? '1 : '0;
  assign m_axi.wlast   = m_axi.wvalid && (send_left_q == CW'(1));
  assign m_axi.bready  = (state_q == StResp);

  assign done_o      = done_q;
  assign done_resp_o = done_resp_q;
  assign busy_o      = (state_q != StIdle);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    fetch_left_d = fetch_left_q;
    send_left_d  = send_left_q;
    done_resp_d  = done_resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          addr_d       = cmd_addr_i;
          len_d        = cmd_len_i;
          fetch_left_d = CW'(cmd_len_i) + CW'(1);
          send_left_d  = CW'(cmd_len_i) + CW'(1);
          state_d      = StAddr;
        end
      end
      StAddr: if (aw_fire) state_d = StData;
      StData: if (w_fire && m_axi.wlast) state_d = StResp;
      StResp: if (b_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (fifo_rden_o) fetch_left_d = fetch_left_q - CW'(1);
    if (w_fire)      send_left_d  = send_left_q - CW'(1);
    if (b_fire)      done_resp_d  = m_axi.bresp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      fetch_left_q <= '0;
      send_left_q  <= '0;
      rd_pend_q    <= 1'b0;
      done_q       <= 1'b0;
      done_resp_q  <= 2'b00;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      fetch_left_q <= fetch_left_d;
      send_left_q  <= send_left_d;
      rd_pend_q    <= fifo_rden_o;
      done_q       <= b_fire;
      done_resp_q  <= done_resp_d;
    end
  end

  axi_burst_writer_skid #(
    .DWID (DWID)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (fifo_dout_i),
    .pop_i       (w_fire),
    .head_o      (buf_head),
    .cnt_o       (buf_cnt)
  );

`ifndef SYNTHESIS
  // Bursts must stay inside one 4 KB page.
  always_ff @(posedge clk) begin
    if (!rst && cmd_fire) begin
      assert ({20'b0, cmd_addr_i[11:0]} +
              ((32'(cmd_len_i) + 32'd1) << size_of(DWID)) <= 32'd4096);
    end
  end
`endif

endmodule
